// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    ADDR,
    LEN,
    DLO,
    DHI,
    CSUM,
    RUN,
    ERR
  } boot_state_e;

endpackage

// File: rtl/boot_loader.sv
// Receives a byte-stream image, writes it into the external RAM, then releases
// the CPU from reset; the RAM port is handed over to the CPU once running.
module boot_loader
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              cpu_ram_w_en,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [DATA_W-1:0] cpu_ram_w_data,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              loading,
  output logic              error
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        lo_q, lo_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              accept;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      addr_q   <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    if (accept) begin
      unique case (state_q)
        SYNC: if (rx_data == SYNC_BYTE) state_d = ADDR;
        ADDR: begin
          addr_d  = rx_data;
          pc_d    = rx_data;
          state_d = LEN;
        end
        LEN: begin
          cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          acc_d   = 8'h00;
          state_d = DLO;
        end
        DLO: begin
          lo_d    = rx_data;
          acc_d   = acc_q + rx_data;
          state_d = DHI;
        end
        DHI: begin
          // The write is issued from registers next cycle, so the address
          // counter can advance right away.
          wrEn_d   = 1'b1;
          wrAddr_d = addr_q;
          wrData_d = {rx_data, lo_q};
          addr_d   = addr_q + 8'd1;
          acc_d    = acc_q + rx_data;
          cnt_d    = cnt_q - 9'd1;
          state_d  = (cnt_q == 9'd1) ? CSUM : DLO;
        end
        CSUM: state_d = (rx_data == acc_q) ? RUN : ERR;
        ERR:  if (rx_data == SYNC_BYTE) state_d = ADDR;
        RUN:  state_d = RUN;
        default: state_d = SYNC;
      endcase
    end
  end

  assign rx_ready   = (state_q != RUN);
  assign cpu_rst_n  = (state_q == RUN);
  assign error      = (state_q == ERR);
  assign loading    = (state_q == ADDR) || (state_q == LEN) || (state_q == DLO) ||
                      (state_q == DHI)  || (state_q == CSUM);
  assign start_pc   = pc_q;
  assign ram_w_en   = cpu_rst_n ? cpu_ram_w_en   : wrEn_q;
  assign ram_addr   = cpu_rst_n ? cpu_ram_addr   : wrAddr_q;
  assign ram_w_data = cpu_rst_n ? cpu_ram_w_data : wrData_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader against an image-level model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        cpu_ram_w_en = 1'b0;
  logic [7:0]  cpu_ram_addr = 8'h00;
  logic [15:0] cpu_ram_w_data = 16'h0000;
  logic        ram_w_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_w_data;
  logic        cpu_rst_n;
  logic [7:0]  start_pc;
  logic        loading;
  logic        error;

  int vecCount  = 0;
  int missCount = 0;

  logic [15:0] words [256];
  logic [23:0] expQ [$];
  logic [23:0] obsQ [$];

  boot_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_ram_w_en(cpu_ram_w_en), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_w_data(cpu_ram_w_data),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .cpu_rst_n(cpu_rst_n), .start_pc(start_pc), .loading(loading), .error(error)
  );

  always #5 clk = ~clk;

  // Loader writes are every RAM write seen while the CPU is held in reset.
  always @(negedge clk) begin
    if (ram_w_en && !cpu_rst_n) obsQ.push_back({ram_addr, ram_w_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetState();
    checkOutput("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("rst_start_pc", {24'd0, start_pc}, 32'h00);
    checkOutput("rst_ram_w_en", {31'd0, ram_w_en}, 32'd0);
    checkOutput("rst_ram_addr", {24'd0, ram_addr}, 32'h00);
    checkOutput("rst_ram_w_data", {16'd0, ram_w_data}, 32'h0000);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_loading", {31'd0, loading}, 32'd0);
    checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  // Offers one byte after a random idle gap; returns once it has been taken.
  task automatic applyStimulus(input logic [7:0] b);
    int tries;
    repeat ($urandom_range(0, 2)) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    cpu_ram_w_en = 1'b1;
    cpu_ram_addr = 8'($urandom);
    cpu_ram_w_data = 16'($urandom);
    rx_valid = 1'b1;
    rx_data = b;
    tries = 0;
    while (!rx_ready && tries < 20) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!rx_ready) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    cpu_ram_w_en = 1'b0;
  endtask

  task automatic compareWrites(input string tag);
    checkOutput({tag, "_nwrites"}, obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput({tag, "_write"}, {8'd0, obsQ[i]}, {8'd0, expQ[i]});
    obsQ.delete();
    expQ.delete();
  endtask

  // Sends an image of n words from words[] to address a and checks the outcome.
  task automatic sendImage(input string tag, input logic [7:0] a, input int n,
                           input int garbage, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] g;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      expQ.push_back({8'((a + i) % 256), words[i]});
      sum = 8'((sum + words[i][7:0] + words[i][15:8]) % 256);
    end
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      applyStimulus(g);
    end
    applyStimulus(8'hA5);
    applyStimulus(a);
    applyStimulus(8'(n % 256));
    for (int i = 0; i < n; i++) begin
      applyStimulus(words[i][7:0]);
      applyStimulus(words[i][15:8]);
    end
    applyStimulus(corrupt ? (sum ^ 8'h3C) : sum);
    checkOutput({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, corrupt ? 32'd0 : 32'd1);
    checkOutput({tag, "_error"}, {31'd0, error}, corrupt ? 32'd1 : 32'd0);
    checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, corrupt ? 32'd1 : 32'd0);
    checkOutput({tag, "_loading"}, {31'd0, loading}, 32'd0);
    checkOutput({tag, "_start_pc"}, {24'd0, start_pc}, {24'd0, a});
    compareWrites(tag);
  endtask

  initial begin
    applyReset();
    checkResetState();

    words[0] = 16'h1234; words[1] = 16'h5678;
    sendImage("basic", 8'h10, 2, 0, 1'b0);

    applyReset();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    words[0] = 16'h0001; words[1] = 16'h0002;
    sendImage("wrap", 8'hFE, 2, 0, 1'b0);

    applyReset();
    words[0] = 16'hBBAA;
    sendImage("badsum", 8'h00, 1, 0, 1'b1);
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    sendImage("recover", 8'($urandom), 3, 2, 1'b0);

    applyReset();
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    sendImage("full256", 8'($urandom), 256, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      applyReset();
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
      sendImage("random", 8'($urandom), $urandom_range(1, 8), $urandom_range(0, 3), t == 3);
    end

    // Reset lands on the same edge that takes the third high byte.
    applyReset();
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    applyStimulus(8'hA5);
    applyStimulus(8'h80);
    applyStimulus(8'h04);
    for (int i = 0; i < 2; i++) begin
      expQ.push_back({8'(8'h80 + i), words[i]});
      applyStimulus(words[i][7:0]);
      applyStimulus(words[i][15:8]);
    end
    applyStimulus(words[2][7:0]);
    rx_valid = 1'b1;
    rx_data = words[2][15:8];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compareWrites("midrst");
    checkResetState();

    // CPU owns the RAM port once running, and the stream is ignored.
    words[0] = 16'hCAFE;
    sendImage("run", 8'h20, 1, 0, 1'b0);
    cpu_ram_w_en = 1'b1;
    cpu_ram_addr = 8'h40;
    cpu_ram_w_data = 16'hBEEF;
    #1;
    checkOutput("run_mux_w_en", {31'd0, ram_w_en}, 32'd1);
    checkOutput("run_mux_addr", {24'd0, ram_addr}, 32'h40);
    checkOutput("run_mux_data", {16'd0, ram_w_data}, 32'hBEEF);
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    cpu_ram_w_en = 1'b0;
    checkOutput("run_hold_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    checkOutput("run_hold_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("run_hold_loading", {31'd0, loading}, 32'd0);
    checkOutput("run_hold_start_pc", {24'd0, start_pc}, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
